// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 main-control FSM: one ALU, one memory port, mem_ready stalls.
// Build option: CTRL_ILLEGAL_TRAP_EN makes an illegal opcode halt in TRAP.
module mips_multicycle_ctrl #(
  parameter int ALUOP_W       = 2,
  parameter int STATE_W       = 4,
  parameter int USE_MEM_READY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Opcode,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSrc,
  output logic               PCEn,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = STATE_W'(0),
    S_FETCH   = STATE_W'(1),
    S_DECODE  = STATE_W'(2),
    S_MEMADR  = STATE_W'(3),
    S_MEMRD   = STATE_W'(4),
    S_MEMWB   = STATE_W'(5),
    S_MEMWR   = STATE_W'(6),
    S_REXEC   = STATE_W'(7),
    S_RWB     = STATE_W'(8),
    S_BRANCH  = STATE_W'(9),
    S_IEXEC   = STATE_W'(10),
    S_IWB     = STATE_W'(11),
    S_JUMP    = STATE_W'(12),
    S_ILLEGAL = STATE_W'(13),
    S_TRAP    = STATE_W'(14)
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_rdy;
  logic [1:0] w_aluop;

  assign w_rdy     = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign ALUOp     = ALUOP_W'(w_aluop);
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

  // State register; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Sticky illegal flag, raised as the FSM enters ILLEGAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_illegal <= 1'b0;
    else if (w_next == S_ILLEGAL)  r_illegal <= 1'b1;
  end

  // Next-state and Moore outputs (FETCH/BRANCH enables qualified).
  always_comb begin
    w_next   = S_IDLE;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    w_aluop  = 2'b00;
    PCSrc    = 2'b00;
    PCEn     = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = w_rdy;
        PCEn    = w_rdy;
        w_next  = w_rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_R:             w_next = S_REXEC;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_ADDI, OP_SLTI: w_next = S_IEXEC;
          OP_J:             w_next = S_JUMP;
          default:          w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = w_rdy ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = w_rdy ? S_FETCH : S_MEMWR;
      end
      S_REXEC: begin
        ALUSrcA = 1'b1;
        w_aluop = 2'b10;
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        w_aluop = 2'b01;
        PCSrc   = 2'b01;
        PCEn    = (Opcode == OP_BEQ) ? Zero : ~Zero;
        w_next  = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_aluop = (Opcode == OP_SLTI) ? 2'b11 : 2'b00;
        w_next  = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        PCSrc  = 2'b10;
        PCEn   = 1'b1;
        w_next = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: w_next = S_TRAP;
      S_TRAP:    w_next = S_TRAP;
`else
      S_ILLEGAL: w_next = S_FETCH;
`endif
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-instruction cycle model
// plus literal checks on latency, reset and mutual exclusion.
module tb_mips_multicycle_ctrl;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DEC = 4'd2;
  localparam logic [3:0] ST_MADR = 4'd3, ST_MRD = 4'd4, ST_MWB = 4'd5;
  localparam logic [3:0] ST_MWR = 4'd6, ST_REX = 4'd7, ST_RWB = 4'd8;
  localparam logic [3:0] ST_BR = 4'd9, ST_IEX = 4'd10, ST_IWB = 4'd11;
  localparam logic [3:0] ST_JMP = 4'd12, ST_ILL = 4'd13, ST_TRAP = 4'd14;

  localparam logic [5:0] R = 6'b000000, J = 6'b000010;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic iord, mrd, mwr, irw, rdst, m2r, rw, sa;
    logic [1:0] sb, aop, pcs;
    logic pcen, ill;
  } ctl_t;

  typedef struct packed {
    logic [5:0] op;
    logic z, rdy;
    ctl_t e;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] Opcode;
  logic Zero, mem_ready;
  logic IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite;
  logic ALUSrcA, PCEn, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [3:0] dbg_state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero),
    .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  ctl_t w_dut;
  assign w_dut = {dbg_state, IorD, MemRead, MemWrite, IRWrite, RegDst,
                  MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                  PCEn, illegal};

  int total = 0;
  int bad = 0;
  ent_t prog[$];
  ctl_t exp_cur;
  logic chk_on = 1'b0;
  logic m_ill = 1'b0;

  int cyc = 0;
  int fst[$];
  logic [3:0] prev_st = 4'd0;
  int mrio = 0, wbcnt = 0, excl = 0;

  function automatic ctl_t blank(input logic [3:0] st);
    ctl_t e;
    e = '0;
    e.st = st;
    e.ill = m_ill;
    return e;
  endfunction

  task automatic push(input logic [5:0] op, input logic z,
                      input logic rdy, input ctl_t e);
    ent_t n;
    n.op = op; n.z = z; n.rdy = rdy; n.e = e;
    prog.push_back(n);
  endtask

  // Expected cycle-by-cycle control for one instruction.
  task automatic instr(input logic [5:0] op, input logic z,
                       input int fw, input int mw);
    ctl_t e;
    for (int i = 0; i < fw; i++) begin
      e = blank(ST_FETCH); e.mrd = 1; e.sb = 2'b01;
      push(op, z, 1'b0, e);
    end
    e = blank(ST_FETCH); e.mrd = 1; e.sb = 2'b01; e.irw = 1; e.pcen = 1;
    push(op, z, 1'b1, e);
    e = blank(ST_DEC); e.sb = 2'b11;
    push(op, z, 1'b0, e);
    case (op)
      LW, SW: begin
        e = blank(ST_MADR); e.sa = 1; e.sb = 2'b10;
        push(op, z, 1'b0, e);
        for (int i = 0; i <= mw; i++) begin
          e = blank(op == LW ? ST_MRD : ST_MWR);
          e.iord = 1;
          if (op == LW) e.mrd = 1; else e.mwr = 1;
          push(op, z, (i == mw), e);
        end
        if (op == LW) begin
          e = blank(ST_MWB); e.m2r = 1; e.rw = 1;
          push(op, z, 1'b0, e);
        end
      end
      R: begin
        e = blank(ST_REX); e.sa = 1; e.aop = 2'b10;
        push(op, z, 1'b0, e);
        e = blank(ST_RWB); e.rdst = 1; e.rw = 1;
        push(op, z, 1'b0, e);
      end
      BEQ, BNE: begin
        e = blank(ST_BR); e.sa = 1; e.aop = 2'b01; e.pcs = 2'b01;
        e.pcen = (op == BEQ) ? z : ~z;
        push(op, z, 1'b0, e);
      end
      ADDI, SLTI: begin
        e = blank(ST_IEX); e.sa = 1; e.sb = 2'b10;
        e.aop = (op == SLTI) ? 2'b11 : 2'b00;
        push(op, z, 1'b0, e);
        e = blank(ST_IWB); e.rw = 1;
        push(op, z, 1'b0, e);
      end
      J: begin
        e = blank(ST_JMP); e.pcs = 2'b10; e.pcen = 1;
        push(op, z, 1'b0, e);
      end
      default: begin
        m_ill = 1'b1;
        push(op, z, 1'b0, blank(ST_ILL));
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) push(op, z, 1'b1, blank(ST_TRAP));
`else
        e = blank(ST_FETCH); e.mrd = 1; e.sb = 2'b01;
        e.irw = 1; e.pcen = 1;
        push(op, z, 1'b1, e);
`endif
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (w_dut !== exp_cur) begin
        bad++;
        $display("FAIL cycle%0d: got %h want %h", cyc, w_dut, exp_cur);
      end
    end
  end

  // Independent monitors for latency and exclusivity.
  always @(negedge clk) begin
    if (chk_on) begin
      cyc <= cyc + 1;
      if (dbg_state == ST_FETCH && prev_st != ST_FETCH) fst.push_back(cyc);
      prev_st <= dbg_state;
      if (MemRead && IorD) mrio <= mrio + 1;
      if (RegWrite && MemToReg) wbcnt <= wbcnt + 1;
      if ((MemRead && MemWrite) || (RegWrite && MemWrite)) excl <= excl + 1;
    end
  end

  initial begin
    int g0, g1;
    rst_n = 1'b0; Opcode = '0; Zero = 1'b0; mem_ready = 1'b1;
    push(R, 1'b0, 1'b1, blank(ST_IDLE));
    instr(R, 1'b0, 0, 0);
    instr(LW, 1'b0, 0, 2);
    instr(SW, 1'b0, 1, 1);
    instr(BEQ, 1'b1, 0, 0);
    instr(BEQ, 1'b0, 0, 0);
    instr(BNE, 1'b1, 0, 0);
    instr(BNE, 1'b0, 0, 0);
    instr(SLTI, 1'b0, 0, 0);
    instr(ADDI, 1'b1, 0, 0);
    instr(J, 1'b0, 0, 0);
    instr(BAD, 1'b0, 0, 0);

    repeat (2) @(posedge clk);
    #1 chk("reset_outputs", 32'(w_dut), 32'd0);
    rst_n = 1'b1;
    foreach (prog[i]) begin
      Opcode = prog[i].op;
      Zero = prog[i].z;
      mem_ready = prog[i].rdy;
      exp_cur = prog[i].e;
      chk_on = 1'b1;
      @(posedge clk);
      #1;
    end
    chk_on = 1'b0;

    g0 = (fst.size() > 2) ? fst[1] - fst[0] : -1;
    g1 = (fst.size() > 2) ? fst[2] - fst[1] : -1;
    chk("r_latency", 32'(g0), 32'd4);
    chk("lw_wait_latency", 32'(g1), 32'd7);
    chk("lw_mread_cycles", 32'(mrio), 32'd3);
    chk("memwb_once", 32'(wbcnt), 32'd1);
    chk("exclusive", 32'(excl), 32'd0);
    chk("illegal_sticky", 32'(illegal), 32'd1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("trap_hold", 32'(dbg_state), 32'(ST_TRAP));
`endif

    #2 rst_n = 1'b0;
    #1 chk("async_clear", 32'(w_dut), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; Opcode = SW; mem_ready = 1'b1;
    chk("post_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1 chk("fetch_read", 32'({dbg_state, MemRead, IRWrite}),
           32'({ST_FETCH, 2'b11}));
    @(posedge clk);
    #1 mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("memwr_held", 32'({dbg_state, MemWrite, IorD}),
           32'({ST_MWR, 2'b11}));
    #2 rst_n = 1'b0;
    #1 chk("memwr_abort", 32'({dbg_state, MemWrite}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; mem_ready = 1'b1;
    @(posedge clk);
    #1 chk("refetch", 32'({dbg_state, MemRead, MemWrite}),
           32'({ST_FETCH, 2'b10}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Parametrised multicycle main-control FSM for the MIPS32 core; successor to the single-cycle opcode decoder. It sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several clocks, sharing one ALU and one memory port. It stalls on a memory-ready handshake and resolves BEQ/BNE from ALU Zero. Opcode comes from the datapath IR, which is stable after DECODE.

Parameters:
ALUOP_W, 2, ALUOp width (≥2); upper bits zero-extended.
STATE_W, 4, state register width (≥4); exported on dbg_state.
USE_MEM_READY, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored, every memory state takes exactly 1 cycle.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
Opcode  in  6  IR[31:26]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
IorD  out  1  0 = address from PC, 1 = address from ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
RegDst  out  1  1 = rd, 0 = rt
MemToReg  out  1  1 = MDR, 0 = ALUOut
RegWrite  out  1  register-file write enable
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
ALUOp  out  ALUOP_W  00 = add, 01 = sub, 10 = funct, 11 = slt
PCSrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
PCEn  out  1  PC write enable
illegal  out  1  sticky illegal-opcode flag
dbg_state  out  STATE_W  current state

Behaviour:
- Moore outputs decoded from state. Exceptions: PCEn and IRWrite in FETCH are qualified by mem_ready; PCEn in BRANCH is qualified by Zero.
- Reset (async, rst_n=0): state = IDLE; every output 0; illegal = 0. Reset mid-instruction aborts with no further writes.
- IDLE (all 0) -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite = PCEn = mem_ready. Hold while !mem_ready; else -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Dispatch: 100011/101011 -> MEMADR; 000000 -> REXEC; 000100/000101 -> BRANCH; 001000/001010 -> IEXEC; 000010 -> JUMP; other -> ILLEGAL.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready -> MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1 -> FETCH.
- MEMWR: MemWrite=1, IorD=1, held until mem_ready; the write commits on the MemWrite & mem_ready cycle. -> FETCH.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB: RegDst=1, MemToReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01; PCEn = BEQ ? Zero : ~Zero. -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10; ALUOp=00 for ADDI, 11 for SLTI. -> IWB.
- IWB: RegDst=0, MemToReg=0, RegWrite=1 -> FETCH.
- JUMP: PCSrc=10, PCEn=1 -> FETCH.
- ILLEGAL: sets illegal (cleared only by reset); no register or memory write. Exit depends on CTRL_ILLEGAL_TRAP_EN.
- Latency, USE_MEM_READY=0 or zero memory wait (IDLE excluded): LW 5, SW 4, R 4, ADDI/SLTI 4, BEQ/BNE 3, J 3. Each memory wait cycle adds 1.
- Unassigned state encodings -> IDLE next cycle, all outputs 0.
- Never asserted together: MemRead with MemWrite; RegWrite with MemWrite.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: ILLEGAL -> TRAP. TRAP holds with all outputs 0 except illegal=1 and is left only by reset (core halts).
- Undefined: ILLEGAL acts as a 1-cycle NOP, then -> FETCH. PC already advanced by 4 in FETCH; illegal still sets.

Test Plan:
- Reset, mem_ready=1, Opcode=000000, Zero=0 -> dbg_state IDLE, FETCH, DECODE, REXEC, RWB, FETCH; RegWrite=1 and RegDst=1 only in RWB; ALUOp=10 in REXEC.
- LW (100011) with mem_ready low for 2 cycles in MEMRD -> MemRead=1, IorD=1 for 3 cycles; MEMWB asserts RegWrite=1, MemToReg=1 exactly once; total 7 cycles FETCH to FETCH.
- BEQ, Zero=1 -> PCEn=1, PCSrc=01 in BRANCH. BEQ, Zero=0 -> PCEn=0. BNE inverts both cases.
- SLTI (001010) -> ALUOp=11, ALUSrcB=10 in IEXEC; RegWrite=1, RegDst=0 in IWB. ADDI -> ALUOp=00.
- Opcode=111111 -> illegal=1. With CTRL_ILLEGAL_TRAP_EN: stuck in TRAP, outputs 0. Without it: back to FETCH after 1 cycle, no RegWrite/MemWrite.
- rst_n low during MEMWR with mem_ready=0 -> MemWrite drops to 0 asynchronously, state IDLE; after release, the next fetch starts at FETCH.
